control_seq: RTL and testbench

- Multi-cycle, registered successor to the nic8 combinational control decoder.
- Sequences each instruction through FETCH and EXEC phases. Latches the instruction word and holds zero/carry flags in its own registers.
- Stalls on a memory-ready handshake, adds a HALT opcode and a retired-instruction counter.
- Sits between the IR/ALU datapath and the register-load/bus-drive strobes of the CPU top level.

---
 rtl/nic8_ctrl_pkg.sv | 60 ++++++
 rtl/ir_decode.sv | 46 ++++
 rtl/control_seq.sv | 183 ++++++++++++++++++
 tb/tb_control_seq.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/nic8_ctrl_pkg.sv
// nic8_ctrl_pkg
// Shared definitions for the nic8 control sequencer:
//   - instruction-register field positions
//   - source / dest encodings (DEST_HALT added for the registered controller)
//   - sequencer state encoding
//   - bit indices of the 14-bit legacy control bundle, so the CPU top level
//     can repack the individual strobes into the old vector layout
package nic8_ctrl_pkg;

    // IR layout, MSB to LSB: {bit7, bit6, source[1:0], dest[2:0], indexed}
    localparam int IR_BIT7     = 7;
    localparam int IR_BIT6     = 6;
    localparam int IR_SRC_MSB  = 5;
    localparam int IR_SRC_LSB  = 4;
    localparam int IR_DEST_MSB = 3;
    localparam int IR_DEST_LSB = 1;
    localparam int IR_INDEXED  = 0;

    typedef enum logic [1:0] {
        SRC_M = 2'd0,
        SRC_E = 2'd1,
        SRC_A = 2'd2,
        SRC_X = 2'd3
    } src_e;

    typedef enum logic [2:0] {
        DEST_IR   = 3'd0,
        DEST_PC   = 3'd1,
        DEST_A    = 3'd2,
        DEST_X    = 3'd3,
        DEST_B    = 3'd4,
        DEST_MEM  = 3'd5,
        DEST_OUT  = 3'd6,
        DEST_HALT = 3'd7
    } dest_e;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_HALT  = 2'd2
    } state_e;

    // Legacy 14-bit control bundle bit positions
    localparam int CTL_W           = 14;
    localparam int CTL_LOAD_IR     = 13;
    localparam int CTL_LOAD_PC     = 12;
    localparam int CTL_LOAD_A      = 11;
    localparam int CTL_LOAD_B      = 10;
    localparam int CTL_LOAD_X      = 9;
    localparam int CTL_DO_OUT      = 8;
    localparam int CTL_STORE_MEM   = 7;
    localparam int CTL_ASSERT_M    = 6;
    localparam int CTL_ASSERT_E    = 5;
    localparam int CTL_ASSERT_A    = 4;
    localparam int CTL_ASSERT_X    = 3;
    localparam int CTL_IMMEDIATE   = 2;
    localparam int CTL_DO_SUBTRACT = 1;
    localparam int CTL_DO_JUMP     = 0;

endpackage

// File: rtl/ir_decode.sv
// ir_decode
// Purely combinational field decode of the latched instruction word.
// Ports:
//   ir        in   latched instruction word
//   flag_z    in   registered zero flag (pre-update value)
//   flag_c    in   registered carry flag (pre-update value)
//   src_oh    out  one-hot source select, indexed by src_e
//   dest_oh   out  one-hot destination, indexed by dest_e
//   immediate out  operand comes from the byte after the opcode (~indexed)
//   subtract  out  ALU subtract mode (bit6)
//   mem_op    out  instruction touches memory (source M or dest Mem)
//   jc        out  jump condition
module ir_decode
    import nic8_ctrl_pkg::*;
(
    input  logic [7:0] ir,
    input  logic       flag_z,
    input  logic       flag_c,
    output logic [3:0] src_oh,
    output logic [7:0] dest_oh,
    output logic       immediate,
    output logic       subtract,
    output logic       mem_op,
    output logic       jc
);

    src_e  src;
    dest_e dest;
    logic  b6;
    logic  b7;

    always_comb begin
        src       = src_e'(ir[IR_SRC_MSB:IR_SRC_LSB]);
        dest      = dest_e'(ir[IR_DEST_MSB:IR_DEST_LSB]);
        b6        = ir[IR_BIT6];
        b7        = ir[IR_BIT7];
        src_oh    = 4'b0001 << src;
        dest_oh   = 8'b0000_0001 << dest;
        immediate = ~ir[IR_INDEXED];
        subtract  = b6;
        mem_op    = (src == SRC_M) || (dest == DEST_MEM);
        // bit6&bit7 together encode an unconditional jump
        jc        = (b6 & flag_z) | (b7 & flag_c) | (b6 & b7);
    end

endmodule

// File: rtl/control_seq.sv
// control_seq
// Registered FETCH/EXEC control sequencer for the nic8 CPU. Latches the
// instruction word, owns the zero/carry flags and a retired-instruction
// counter, and stalls memory operations on mem_ready.
//
// state | meaning
// FETCH | drive M onto the bus, capture IR when memory is ready
// EXEC  | decode ir_q, strobe loads once the cycle completes
// HALT  | everything idle until reset
//
// Ports:
//   clk, reset_n          system clock, synchronous active-low reset
//   mem_data, mem_ready   memory read bus and its ready handshake
//   alu_result, alu_carry ALU outputs, sampled only into the flag registers
//   loadIR..storeMem      register-load strobes
//   assertM..assertX      one-hot bus-source select
//   immediate, doSubtract, doJump  datapath mode bits
//   pc_inc                increment PC this cycle
//   halted                high while in HALT
//   flag_z, flag_c        registered flags
//   retired               completed EXEC phases, wraps
module control_seq
    import nic8_ctrl_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [7:0]        mem_data,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_carry,
    output logic              loadIR,
    output logic              loadPC,
    output logic              loadA,
    output logic              loadB,
    output logic              loadX,
    output logic              doOut,
    output logic              storeMem,
    output logic              assertM,
    output logic              assertE,
    output logic              assertA,
    output logic              assertX,
    output logic              immediate,
    output logic              doSubtract,
    output logic              doJump,
    output logic              pc_inc,
    output logic              halted,
    output logic              flag_z,
    output logic              flag_c,
    output logic [CNT_W-1:0]  retired
);

    state_e           state;
    state_e           state_nxt;
    logic [7:0]       ir_q;
    logic [7:0]       ir_nxt;
    logic [CTL_W-1:0] ctl;
    logic [CTL_W-1:0] ctl_out;
    logic             pc_inc_c;
    logic             retire;
    logic             complete;

    logic [3:0]       src_oh;
    logic [7:0]       dest_oh;
    logic             dec_imm;
    logic             dec_sub;
    logic             mem_op;
    logic             jc;

    ir_decode u_ir_decode (
        .ir        (ir_q),
        .flag_z    (flag_z),
        .flag_c    (flag_c),
        .src_oh    (src_oh),
        .dest_oh   (dest_oh),
        .immediate (dec_imm),
        .subtract  (dec_sub),
        .mem_op    (mem_op),
        .jc        (jc)
    );

    always_comb begin
        state_nxt = state;
        ir_nxt    = ir_q;
        ctl       = '0;
        pc_inc_c  = 1'b0;
        retire    = 1'b0;
        complete  = 1'b0;
        case (state)
            ST_FETCH: begin
                ctl[CTL_ASSERT_M] = 1'b1;
                pc_inc_c          = mem_ready;
                if (mem_ready) begin
                    ir_nxt    = mem_data;
                    state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                // selects and mode bits stay up through any stall
                ctl[CTL_ASSERT_M]     = src_oh[SRC_M];
                ctl[CTL_ASSERT_E]     = src_oh[SRC_E];
                ctl[CTL_ASSERT_A]     = src_oh[SRC_A];
                ctl[CTL_ASSERT_X]     = src_oh[SRC_X];
                ctl[CTL_IMMEDIATE]    = dec_imm;
                ctl[CTL_DO_SUBTRACT]  = dec_sub;
                complete = mem_ready | ~mem_op;
                if (complete) begin
                    retire = 1'b1;
                    if (dest_oh[DEST_HALT]) begin
                        state_nxt = ST_HALT;
                    end else begin
                        ctl[CTL_LOAD_IR]   = dest_oh[DEST_IR];
                        ctl[CTL_LOAD_PC]   = dest_oh[DEST_PC] & jc;
                        ctl[CTL_DO_JUMP]   = dest_oh[DEST_PC] & jc;
                        ctl[CTL_LOAD_A]    = dest_oh[DEST_A];
                        ctl[CTL_LOAD_X]    = dest_oh[DEST_X];
                        ctl[CTL_LOAD_B]    = dest_oh[DEST_B];
                        ctl[CTL_STORE_MEM] = dest_oh[DEST_MEM];
                        ctl[CTL_DO_OUT]    = dest_oh[DEST_OUT];
                        pc_inc_c           = dec_imm & src_oh[SRC_M];
                        if (dest_oh[DEST_IR]) begin
                            // only memory can feed IR here; other sources degrade to a NOP
                            ir_nxt    = src_oh[SRC_M] ? mem_data : 8'h00;
                            state_nxt = ST_EXEC;
                        end else begin
                            state_nxt = ST_FETCH;
                        end
                    end
                end
            end
            ST_HALT: begin
                state_nxt = ST_HALT;
            end
            default: begin
                state_nxt = ST_FETCH;
            end
        endcase
    end

    // reset suppresses every strobe in the cycle it is asserted
    assign ctl_out    = reset_n ? ctl : '0;
    assign pc_inc     = reset_n & pc_inc_c;
    assign halted     = (state == ST_HALT);

    assign loadIR     = ctl_out[CTL_LOAD_IR];
    assign loadPC     = ctl_out[CTL_LOAD_PC];
    assign loadA      = ctl_out[CTL_LOAD_A];
    assign loadB      = ctl_out[CTL_LOAD_B];
    assign loadX      = ctl_out[CTL_LOAD_X];
    assign doOut      = ctl_out[CTL_DO_OUT];
    assign storeMem   = ctl_out[CTL_STORE_MEM];
    assign assertM    = ctl_out[CTL_ASSERT_M];
    assign assertE    = ctl_out[CTL_ASSERT_E];
    assign assertA    = ctl_out[CTL_ASSERT_A];
    assign assertX    = ctl_out[CTL_ASSERT_X];
    assign immediate  = ctl_out[CTL_IMMEDIATE];
    assign doSubtract = ctl_out[CTL_DO_SUBTRACT];
    assign doJump     = ctl_out[CTL_DO_JUMP];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= ST_FETCH;
            ir_q    <= '0;
            flag_z  <= 1'b0;
            flag_c  <= 1'b0;
            retired <= '0;
        end else begin
            state <= state_nxt;
            ir_q  <= ir_nxt;
            // loadA only rises on a completing A-dest cycle
            if (ctl[CTL_LOAD_A]) begin
                flag_z <= (alu_result == '0);
                flag_c <= alu_carry;
            end
            if (retire) begin
                retired <= retired + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_control_seq.sv
module tb_control_seq;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] mem_data = 8'h00;
    logic       mem_ready = 1'b0;
    logic [7:0] alu_result = 8'h00;
    logic       alu_carry = 1'b0;

    logic loadIR, loadPC, loadA, loadB, loadX, doOut, storeMem;
    logic assertM, assertE, assertA, assertX, immediate, doSubtract, doJump;
    logic pc_inc, halted, flag_z, flag_c;
    logic [15:0] retired;

    logic loadIR_4, loadPC_4, loadA_4, loadB_4, loadX_4, doOut_4, storeMem_4;
    logic assertM_4, assertE_4, assertA_4, assertX_4, immediate_4, doSubtract_4, doJump_4;
    logic pc_inc_4, halted_4, flag_z_4, flag_c_4;
    logic [3:0] retired_4;

    always #5 clk = ~clk;

    control_seq #(.DATA_W(8), .CNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .mem_data(mem_data), .mem_ready(mem_ready),
        .alu_result(alu_result), .alu_carry(alu_carry),
        .loadIR(loadIR), .loadPC(loadPC), .loadA(loadA), .loadB(loadB), .loadX(loadX),
        .doOut(doOut), .storeMem(storeMem), .assertM(assertM), .assertE(assertE),
        .assertA(assertA), .assertX(assertX), .immediate(immediate),
        .doSubtract(doSubtract), .doJump(doJump), .pc_inc(pc_inc), .halted(halted),
        .flag_z(flag_z), .flag_c(flag_c), .retired(retired)
    );

    control_seq #(.DATA_W(8), .CNT_W(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .mem_data(mem_data), .mem_ready(mem_ready),
        .alu_result(alu_result), .alu_carry(alu_carry),
        .loadIR(loadIR_4), .loadPC(loadPC_4), .loadA(loadA_4), .loadB(loadB_4), .loadX(loadX_4),
        .doOut(doOut_4), .storeMem(storeMem_4), .assertM(assertM_4), .assertE(assertE_4),
        .assertA(assertA_4), .assertX(assertX_4), .immediate(immediate_4),
        .doSubtract(doSubtract_4), .doJump(doJump_4), .pc_inc(pc_inc_4), .halted(halted_4),
        .flag_z(flag_z_4), .flag_c(flag_c_4), .retired(retired_4)
    );

    localparam logic [14:0] L_IR = 15'h4000, L_PC = 15'h2000, L_A  = 15'h1000, L_B  = 15'h0800;
    localparam logic [14:0] L_X  = 15'h0400, DOUT = 15'h0200, ST   = 15'h0100, A_M  = 15'h0080;
    localparam logic [14:0] A_E  = 15'h0040, A_A  = 15'h0020, A_X  = 15'h0010, IMM  = 15'h0008;
    localparam logic [14:0] SUB  = 15'h0004, JMP  = 15'h0002, PCI  = 15'h0001;
    localparam logic [14:0] STROBE_MASK = L_IR | L_PC | L_A | L_B | L_X | DOUT | ST | JMP | PCI;

    logic [14:0] act;
    always_comb act = {loadIR, loadPC, loadA, loadB, loadX, doOut, storeMem,
                       assertM, assertE, assertA, assertX, immediate, doSubtract, doJump, pc_inc};

    typedef struct {
        logic        rst_n;
        logic [7:0]  md;
        logic        mr;
        logic [7:0]  alu;
        logic        ac;
        logic [14:0] exp_s;
        logic        ez;
        logic        ec;
        logic [15:0] eret;
    } vec_t;

    vec_t tv[21];
    int n_chk = 0;
    int n_pass = 0;

    function automatic vec_t mkv(input logic r, input logic [7:0] md, input logic mr,
                                 input logic [7:0] alu, input logic ac, input logic [14:0] s,
                                 input logic z, input logic c, input logic [15:0] ret);
        vec_t v;
        v.rst_n = r; v.md = md; v.mr = mr; v.alu = alu; v.ac = ac;
        v.exp_s = s; v.ez = z; v.ec = c; v.eret = ret;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic [7:0] md, input logic mr);
        reset_n = r;
        mem_data = md;
        mem_ready = mr;
    endtask

    initial begin
        // LDA imm / JZ taken / LDA nonzero / JZ not taken / LDA with carry-jump bits /
        // MOV A->B / fetch stall / LD IR / LDA / OUT / JC taken
        tv[0]  = mkv(0, 8'h04, 1, 8'h00, 0, 15'h0,                       0, 0, 16'd0);
        tv[1]  = mkv(1, 8'h04, 1, 8'h00, 0, A_M|PCI,                     0, 0, 16'd0);
        tv[2]  = mkv(1, 8'h04, 1, 8'h00, 0, L_A|A_M|IMM|PCI,             0, 0, 16'd0);
        tv[3]  = mkv(1, 8'h42, 1, 8'h00, 0, A_M|PCI,                     1, 0, 16'd1);
        tv[4]  = mkv(1, 8'h42, 1, 8'h00, 0, L_PC|A_M|IMM|SUB|JMP|PCI,    1, 0, 16'd1);
        tv[5]  = mkv(1, 8'h04, 1, 8'h05, 1, A_M|PCI,                     1, 0, 16'd2);
        tv[6]  = mkv(1, 8'h04, 1, 8'h05, 1, L_A|A_M|IMM|PCI,             1, 0, 16'd2);
        tv[7]  = mkv(1, 8'h42, 1, 8'h00, 0, A_M|PCI,                     0, 1, 16'd3);
        tv[8]  = mkv(1, 8'h42, 1, 8'h00, 0, A_M|IMM|SUB|PCI,             0, 1, 16'd3);
        tv[9]  = mkv(1, 8'h84, 1, 8'h03, 0, A_M|PCI,                     0, 1, 16'd4);
        tv[10] = mkv(1, 8'h84, 1, 8'h03, 0, L_A|A_M|IMM|PCI,             0, 1, 16'd4);
        tv[11] = mkv(1, 8'h28, 1, 8'h00, 1, A_M|PCI,                     0, 0, 16'd5);
        tv[12] = mkv(1, 8'h28, 0, 8'h00, 1, L_B|A_A|IMM,                 0, 0, 16'd5);
        tv[13] = mkv(1, 8'h04, 0, 8'h00, 0, A_M,                         0, 0, 16'd6);
        tv[14] = mkv(1, 8'h01, 1, 8'h00, 0, A_M|PCI,                     0, 0, 16'd6);
        tv[15] = mkv(1, 8'h04, 1, 8'h00, 0, L_IR|A_M,                    0, 0, 16'd6);
        tv[16] = mkv(1, 8'h04, 1, 8'h00, 1, L_A|A_M|IMM|PCI,             0, 0, 16'd7);
        tv[17] = mkv(1, 8'h2C, 1, 8'h00, 0, A_M|PCI,                     1, 1, 16'd8);
        tv[18] = mkv(1, 8'h2C, 0, 8'h00, 0, DOUT|A_A|IMM,                1, 1, 16'd8);
        tv[19] = mkv(1, 8'h82, 1, 8'h00, 0, A_M|PCI,                     1, 1, 16'd9);
        tv[20] = mkv(1, 8'h82, 1, 8'h00, 0, L_PC|A_M|IMM|JMP|PCI,        1, 1, 16'd9);

        tick();
        tick();

        for (int i = 0; i < 21; i++) begin
            drive(tv[i].rst_n, tv[i].md, tv[i].mr);
            alu_result = tv[i].alu;
            alu_carry = tv[i].ac;
            @(negedge clk);
            chk($sformatf("vec%0d strobes", i), {17'b0, act}, {17'b0, tv[i].exp_s});
            chk($sformatf("vec%0d halted", i), {31'b0, halted}, 32'd0);
            chk($sformatf("vec%0d flags", i), {30'b0, flag_z, flag_c}, {30'b0, tv[i].ez, tv[i].ec});
            chk($sformatf("vec%0d retired", i), {16'b0, retired}, {16'b0, tv[i].eret});
            tick();
        end
        alu_result = 8'h00;
        alu_carry = 1'b0;

        // store A with three stall cycles
        drive(1, 8'h2A, 1);
        @(negedge clk); chk("st fetch", {17'b0, act}, {17'b0, A_M|PCI});
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1, 8'h00, 0);
            @(negedge clk);
            chk($sformatf("st stall%0d", i), {17'b0, act}, {17'b0, A_A|IMM});
            chk($sformatf("st stall%0d ret", i), {16'b0, retired}, 32'd10);
            tick();
        end
        drive(1, 8'h00, 1);
        @(negedge clk); chk("st complete", {17'b0, act}, {17'b0, ST|A_A|IMM});
        tick();
        drive(1, 8'h00, 0);
        @(negedge clk);
        chk("st after", {17'b0, act}, {17'b0, A_M});
        chk("st retired", {16'b0, retired}, 32'd11);

        // HALT
        tick();
        drive(1, 8'h0E, 1);
        @(negedge clk); chk("halt fetch", {17'b0, act}, {17'b0, A_M|PCI});
        tick();
        @(negedge clk);
        chk("halt exec strobes", {17'b0, act & STROBE_MASK}, 32'd0);
        chk("halt exec halted", {31'b0, halted}, 32'd0);
        tick();
        for (int i = 0; i < 10; i++) begin
            drive(1, 8'hFF, i[0]);
            @(negedge clk);
            chk($sformatf("halt%0d strobes", i), {17'b0, act}, 32'd0);
            chk($sformatf("halt%0d halted", i), {31'b0, halted}, 32'd1);
            tick();
        end
        chk("halt retired", {16'b0, retired}, 32'd12);
        drive(0, 8'h00, 1);
        @(negedge clk); chk("halt reset strobes", {17'b0, act}, 32'd0);
        tick();
        drive(1, 8'h00, 0);
        @(negedge clk);
        chk("post reset halted", {31'b0, halted}, 32'd0);
        chk("post reset strobes", {17'b0, act}, {17'b0, A_M});
        chk("post reset retired", {16'b0, retired}, 32'd0);
        chk("post reset flags", {30'b0, flag_z, flag_c}, 32'd0);
        tick();

        // 17 retirements: 16-bit counter reads 17, 4-bit counter wraps to 1
        for (int i = 0; i < 17; i++) begin
            drive(1, 8'h28, 1);
            tick();
            drive(1, 8'h00, 0);
            tick();
        end
        @(negedge clk);
        chk("wrap cnt16", {16'b0, retired}, 32'd17);
        chk("wrap cnt4", {28'b0, retired_4}, 32'd1);
        tick();

        // reset during an EXEC stall aborts the store
        drive(1, 8'h2A, 1);
        tick();
        drive(1, 8'h00, 0);
        @(negedge clk); chk("abort stall", {17'b0, act}, {17'b0, A_A|IMM});
        tick();
        drive(0, 8'h00, 1);
        @(negedge clk); chk("abort strobes", {17'b0, act}, 32'd0);
        tick();
        drive(1, 8'h00, 0);
        @(negedge clk);
        chk("abort state", {17'b0, act}, {17'b0, A_M});
        chk("abort retired", {16'b0, retired}, 32'd0);
        chk("abort retired4", {28'b0, retired_4}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
